// File: rtl/calc_port_master.sv
// Calculator port master: issues tagged two-beat requests (command+op1, then op2)
// to a calculator port and forwards its tagged responses with 1-cycle latency.
module calc_port_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 4,
    parameter int TAG_WIDTH  = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CMD_WIDTH-1:0]  req_cmd,
    input  logic [DATA_WIDTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0] req_op2,
    output logic [CMD_WIDTH-1:0]  cmd_in,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [TAG_WIDTH-1:0]  tag_in,
    input  logic [1:0]            resp_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_resp,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  timeout_err,
    output logic                  spurious_err
);
    localparam int NUM_TAGS = 2 ** TAG_WIDTH;
    localparam int AGE_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        OP2  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CMD_WIDTH-1:0]  cmd_in_q, cmd_in_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [TAG_WIDTH-1:0]  tag_in_q, tag_in_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [AGE_W-1:0]      age_q [NUM_TAGS];
    logic [AGE_W-1:0]      age_d [NUM_TAGS];
    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  spurious_err_q, spurious_err_d;

    logic                  free_found;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic                  accept;
    logic                  resp_hit;
    logic                  resp_spurious;
    logic [TAG_WIDTH:0]    busy_count;

    // Lowest free tag from the pre-edge busy vector, so a tag released this
    // cycle only becomes allocatable on the next one.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        free_found = 1'b0;
        alloc_tag  = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                alloc_tag  = TAG_WIDTH'(i);
            end
        end
    end

    assign req_ready     = !reset && (state_q == IDLE || state_q == OP2) && free_found;
    assign accept        = req_valid && req_ready;
    assign resp_hit      = (resp_out != 2'd0) && busy_q[tag_out];
    assign resp_spurious = (resp_out != 2'd0) && !busy_q[tag_out];

    // Port sequencer: the calculator-side outputs are computed for the
    // state being entered and registered alongside it.
    always_comb begin
        state_d   = state_q;
        cmd_in_d  = '0;
        data_in_d = '0;
        tag_in_d  = '0;
        op2_d     = op2_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = CMD;
            end
            CMD: begin
                state_d   = OP2;
                data_in_d = op2_q;
            end
            OP2: begin
                state_d = accept ? CMD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cmd_in_d  = req_cmd;
            data_in_d = req_op1;
            tag_in_d  = alloc_tag;
            op2_d     = req_op2;
        end
    end

    // Tag bookkeeping, ageing and response forwarding.
    always_comb begin
        busy_d         = busy_q;
        timeout_err_d  = timeout_err_q;
        spurious_err_d = spurious_err_q | resp_spurious;
        rsp_valid_d    = resp_hit;
        rsp_resp_d     = resp_hit ? resp_out : 2'd0;
        rsp_data_d     = resp_hit ? data_out : '0;
        rsp_tag_d      = resp_hit ? tag_out  : '0;

        if (resp_hit) busy_d[tag_out] = 1'b0;
        if (accept)   busy_d[alloc_tag] = 1'b1;

        for (int i = 0; i < NUM_TAGS; i++) begin
            age_d[i] = age_q[i];
            if (accept && alloc_tag == TAG_WIDTH'(i)) begin
                age_d[i] = '0;
            end else if (busy_q[i] && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
                if (age_d[i] == AGE_MAX) timeout_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            busy_count = busy_count + {{TAG_WIDTH{1'b0}}, busy_q[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cmd_in_q       <= '0;
            data_in_q      <= '0;
            tag_in_q       <= '0;
            op2_q          <= '0;
            busy_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_resp_q     <= '0;
            rsp_data_q     <= '0;
            rsp_tag_q      <= '0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
            // NOTE: the age array is reset too; a stale age would raise a false timeout.
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q        <= state_d;
            cmd_in_q       <= cmd_in_d;
            data_in_q      <= data_in_d;
            tag_in_q       <= tag_in_d;
            op2_q          <= op2_d;
            busy_q         <= busy_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_data_q     <= rsp_data_d;
            rsp_tag_q      <= rsp_tag_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= age_d[i];
        end
    end

    assign cmd_in       = cmd_in_q;
    assign data_in      = data_in_q;
    assign tag_in       = tag_in_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign outstanding  = busy_count;
    assign timeout_err  = timeout_err_q;
    assign spurious_err = spurious_err_q;

endmodule

// File: tb/tb_calc_port_master.sv
// Self-checking bench for calc_port_master: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_calc_port_master;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int TW  = 2;
    localparam int NT  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_cmd;
    logic [DW-1:0] req_op1, req_op2;
    logic [CW-1:0] cmd_in;
    logic [DW-1:0] data_in;
    logic [TW-1:0] tag_in;
    logic [1:0]    resp_out;
    logic [DW-1:0] data_out;
    logic [TW-1:0] tag_out;
    logic          rsp_valid;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [TW:0]   outstanding;
    logic          timeout_err, spurious_err;

    calc_port_master #(
        .DATA_WIDTH(DW), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .cmd_in(cmd_in), .data_in(data_in), .tag_in(tag_in),
        .resp_out(resp_out), .data_out(data_out), .tag_out(tag_out),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .outstanding(outstanding), .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: each accepted request becomes two port words in a queue,
    // popped one per clock; tags are a busy set with allocation timestamps.
    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } word_t;

    word_t         port_q[$];
    word_t         m_word;
    logic [NT-1:0] m_busy;
    int            m_alloc_at[NT];
    int            edge_n;
    logic          m_rv;
    logic [1:0]    m_rr;
    logic [DW-1:0] m_rd;
    logic [TW-1:0] m_rt;
    logic          m_to, m_sp;

    function automatic logic model_ready();
        return (port_q.size() == 0) && (m_busy != '1);
    endfunction

    task automatic model_reset();
        port_q.delete();
        m_word = '0;
        m_busy = '0;
        for (int i = 0; i < NT; i++) m_alloc_at[i] = 0;
        edge_n = 0;
        m_rv = 1'b0; m_rr = '0; m_rd = '0; m_rt = '0;
        m_to = 1'b0; m_sp = 1'b0;
    endtask

    task automatic model_edge();
        logic [NT-1:0] nb;
        logic          acc;
        int            t;
        word_t         w;
        edge_n++;
        acc = req_valid && model_ready();
        for (int i = 0; i < NT; i++)
            if (m_busy[i] && (edge_n - m_alloc_at[i]) == TMO) m_to = 1'b1;
        nb = m_busy;
        m_rv = 1'b0; m_rr = '0; m_rd = '0; m_rt = '0;
        if (resp_out != 2'd0) begin
            if (m_busy[tag_out]) begin
                nb[tag_out] = 1'b0;
                m_rv = 1'b1; m_rr = resp_out; m_rd = data_out; m_rt = tag_out;
            end else begin
                m_sp = 1'b1;
            end
        end
        if (acc) begin
            t = 0;
            while (m_busy[t]) t++;
            nb[t] = 1'b1;
            m_alloc_at[t] = edge_n;
            w.cmd = req_cmd; w.data = req_op1; w.tag = TW'(t);
            port_q.push_back(w);
            w.cmd = '0; w.data = req_op2; w.tag = '0;
            port_q.push_back(w);
        end
        m_busy = nb;
        if (port_q.size() > 0) m_word = port_q.pop_front();
        else m_word = '0;
    endtask

    task automatic check_outputs();
        check("cmd_in", cmd_in, m_word.cmd);
        check("data_in", data_in, m_word.data);
        check("tag_in", tag_in, m_word.tag);
        check("outstanding", outstanding, $countones(m_busy));
        check("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            check("rsp_resp", rsp_resp, m_rr);
            check("rsp_data", rsp_data, m_rd);
            check("rsp_tag", rsp_tag, m_rt);
        end
        check("timeout_err", timeout_err, m_to);
        check("spurious_err", spurious_err, m_sp);
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic cycle(input logic v, input logic [CW-1:0] cmd, input logic [DW-1:0] op1,
                         input logic [DW-1:0] op2, input logic [1:0] resp,
                         input logic [TW-1:0] rtag, input logic [DW-1:0] rdata);
        check_outputs();
        req_valid = v; req_cmd = cmd; req_op1 = op1; req_op2 = op2;
        resp_out = resp; tag_out = rtag; data_out = rdata;
        #1;
        check("req_ready", req_ready, model_ready());
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 2'd0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        resp_out = 2'd0;
        #1;
        check("rst_cmd_in", cmd_in, 0);
        check("rst_data_in", data_in, 0);
        check("rst_tag_in", tag_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_spurious_err", spurious_err, 0);
        check("rst_req_ready", req_ready, 0);
        model_reset();
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_held", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
    endtask

    int            nseen;
    logic [TW-1:0] seen[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic          v;
        logic [1:0]    rs;
        logic [TW-1:0] rt;

        reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
        resp_out = '0; data_out = '0; tag_out = '0;
        #2;
        do_reset();

        // Single request: command beat then operand beat, accepted on first edge.
        cycle(1'b1, 4'd1, 32'd5, 32'd7, 2'd0, '0, '0);
        check("a_cmd", cmd_in, 1);
        check("a_op1", data_in, 5);
        check("a_tag", tag_in, 0);
        idle(1);
        check("a_cmd0", cmd_in, 0);
        check("a_op2", data_in, 7);
        check("a_outst", outstanding, 1);
        idle(1);
        check("a_idle_data", data_in, 0);

        // Back-to-back requests with no responses until all tags are busy.
        do_reset();
        nseen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 4'd2, DW'(k), DW'(100 + k), 2'd0, '0, '0);
            if (cmd_in == 4'd2 && nseen < 8) begin
                seen[nseen] = tag_in;
                nseen++;
            end
        end
        check("b_issued", nseen, 4);
        for (int i = 0; i < 4; i++) check("b_tag_order", seen[i], i);
        check("b_outst", outstanding, 4);
        check("b_ready_full", req_ready, 0);

        // Response on a busy tag, then a free/allocate collision in one cycle.
        cycle(1'b0, '0, '0, '0, 2'd1, 2'd2, 32'hC);
        check("c_rsp_valid", rsp_valid, 1);
        check("c_rsp_tag", rsp_tag, 2);
        check("c_rsp_data", rsp_data, 32'hC);
        check("c_rsp_resp", rsp_resp, 1);
        check("c_outst", outstanding, 3);
        cycle(1'b1, 4'd6, 32'h11, 32'h22, 2'd1, 2'd0, 32'h55);
        check("c_alloc_not_freed", tag_in, 2);
        check("c_cmd", cmd_in, 6);
        check("c_outst2", outstanding, 3);
        idle(1);
        check("c_op2", data_in, 32'h22);
        cycle(1'b1, 4'd5, 32'h1, 32'h2, 2'd0, '0, '0);
        check("c_realloc0", tag_in, 0);
        idle(2);

        // Response on a free tag is dropped and flagged.
        do_reset();
        cycle(1'b0, '0, '0, '0, 2'd1, 2'd3, 32'hAB);
        check("d_no_rsp", rsp_valid, 0);
        check("d_spurious", spurious_err, 1);
        idle(5);
        check("d_sticky", spurious_err, 1);

        // Timeout flag rises exactly TIMEOUT cycles after allocation.
        do_reset();
        cycle(1'b1, 4'd1, 32'h3, 32'h4, 2'd0, '0, '0);
        idle(TMO - 1);
        check("e_before", timeout_err, 0);
        idle(1);
        check("e_at", timeout_err, 1);
        check("e_still_busy", outstanding, 1);

        // Reset in the operand beat with all tags busy.
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, 4'd9, DW'(k + 1), DW'(32'h50 + k), 2'd0, '0, '0);
        idle(1);
        check("f_in_op2", data_in, 32'h56);
        check("f_full", outstanding, 4);
        #2;
        do_reset();
        cycle(1'b1, 4'd3, 32'h77, 32'h88, 2'd0, '0, '0);
        check("f_tag0", tag_in, 0);
        check("f_cmd", cmd_in, 3);
        idle(1);
        check("f_op2", data_in, 32'h88);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                #3;
                do_reset();
            end
            v  = ($urandom_range(0, 99) < 60);
            rs = ($urandom_range(0, 99) < 35) ? 2'($urandom_range(1, 3)) : 2'd0;
            rt = TW'($urandom_range(0, NT - 1));
            if (m_busy != '0 && $urandom_range(0, 9) < 8)
                while (!m_busy[rt]) rt = rt + 1'b1;
            cycle(v, CW'($urandom), $urandom, $urandom, rs, rt, $urandom);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
